// File: rtl/core_pkg.sv
// Shared pipeline definitions: result-source encodings, MEM bus FSM states, MEM/WB payload.
package core_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;
  localparam logic [1:0] RESULT_SRC_IMM  = 2'b11;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   pc_plus_4;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_W-1:0]  rd;
  } mem_wb_t;

endpackage

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus handshake: IDLE/WAIT FSM with a saturating wait counter and timeout abort.
module dmem_bus_ctrl
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_access,
  input  logic i_misaligned,
  input  logic i_ack,
  output logic o_dmem_req,
  output logic o_mem_stall,
  output logic o_done,
  output logic o_timeout_abort
);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic             w_req;
  logic             w_timeout;

  // A request goes out only for aligned accesses; the abort fires on the last allowed wait cycle
  assign w_req           = i_access & ~i_misaligned;
  assign w_timeout       = w_req & (r_state == MEM_WAIT) & ~i_ack &
                           (r_count == CNT_W'(TIMEOUT_CYCLES));
  assign o_dmem_req      = w_req;
  assign o_done          = w_req & i_ack;
  assign o_timeout_abort = w_timeout;
  assign o_mem_stall     = w_req & ~i_ack & ~w_timeout;

  // State and wait counter; the counter saturates at the timeout value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MEM_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_req && !i_ack) begin
            r_state <= MEM_WAIT;
            r_count <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!w_req || i_ack || w_timeout) begin
            r_state <= MEM_IDLE;
            r_count <= '0;
          end else if (r_count != CNT_W'(TIMEOUT_CYCLES)) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
          r_state <= MEM_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stage_memory.sv
// Pipeline MEM stage: word load/store over a req/ack bus, alignment check, MEM/WB register.
module stage_memory
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_clear,
  input  logic             mem_reg_write,
  input  logic             mem_mem_write,
  input  logic [1:0]       mem_result_src,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_write_data,
  input  logic [XLEN-1:0]  mem_pc_plus_4,
  input  logic [XLEN-1:0]  mem_imm_ext,
  input  logic [REG_W-1:0] mem_rd,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             mem_stall,
  output logic             mem_fault,
  output logic             wb_reg_write,
  output logic [1:0]       wb_result_src,
  output logic [XLEN-1:0]  wb_alu_result,
  output logic [XLEN-1:0]  wb_read_data,
  output logic [XLEN-1:0]  wb_pc_plus_4,
  output logic [XLEN-1:0]  wb_imm_ext,
  output logic [REG_W-1:0] wb_rd
);

  logic    w_is_load;
  logic    w_access;
  logic    w_misaligned;
  logic    w_stall;
  logic    w_done;
  logic    w_timeout_abort;
  mem_wb_t w_wb_next;
  mem_wb_t r_wb;
  logic    r_fault;

  assign w_is_load    = (mem_result_src == RESULT_SRC_LOAD);
  assign w_access     = mem_mem_write | w_is_load;
  assign w_misaligned = w_access & (mem_alu_result[1:0] != 2'b00);

  dmem_bus_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_bus_ctrl (
    .clk             (clk),
    .rst             (rst),
    .i_access        (w_access),
    .i_misaligned    (w_misaligned),
    .i_ack           (dmem_ack),
    .o_dmem_req      (dmem_req),
    .o_mem_stall     (w_stall),
    .o_done          (w_done),
    .o_timeout_abort (w_timeout_abort)
  );

  assign mem_stall  = w_stall;
  assign dmem_we    = mem_mem_write;
  assign dmem_addr  = {mem_alu_result[XLEN-1:2], 2'b00};
  assign dmem_wdata = mem_write_data;

  // Next MEM/WB entry: bubble on flush or stall, otherwise copy with load data captured on completion
  always_comb begin
    w_wb_next = '0;
    if (!(wb_clear || w_stall)) begin
      w_wb_next.reg_write  = mem_reg_write;
      w_wb_next.result_src = mem_result_src;
      w_wb_next.alu_result = mem_alu_result;
      w_wb_next.read_data  = (w_is_load && w_done) ? dmem_rdata : '0;
      w_wb_next.pc_plus_4  = mem_pc_plus_4;
      w_wb_next.imm_ext    = mem_imm_ext;
      w_wb_next.rd         = mem_rd;
    end
  end

  // MEM/WB register and the one-cycle fault pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb    <= '0;
      r_fault <= 1'b0;
    end else begin
      r_wb    <= w_wb_next;
      r_fault <= w_misaligned | w_timeout_abort;
    end
  end

  assign mem_fault     = r_fault;
  assign wb_reg_write  = r_wb.reg_write;
  assign wb_result_src = r_wb.result_src;
  assign wb_alu_result = r_wb.alu_result;
  assign wb_read_data  = r_wb.read_data;
  assign wb_pc_plus_4  = r_wb.pc_plus_4;
  assign wb_imm_ext    = r_wb.imm_ext;
  assign wb_rd         = r_wb.rd;

endmodule
